// File: rtl/fp_div_seq.sv
// fp_div_seq -- multi-cycle IEEE754 single-precision divider (a / b).
//
// One operation in flight. Operands are captured in IDLE, classified in CHECK,
// special cases resolve straight to DONE, normal operands run an iterative
// restoring mantissa divide (DIV), then round/normalise/pack (NORM).
//
// Configuration macro: FP_DIV_RNE_EN
//   defined   -> round-to-nearest-even in NORM
//   undefined -> truncate (guard/round/sticky discarded); latency identical
//
// Parameters:
//   BITS_PER_CYC  quotient bits per DIV cycle (1 or 2)
//   NAN_NUM       pattern driven on every NaN result
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_valid/ready   operand handshake; a = dividend, b = divisor
//   out_valid/ready  result handshake; out = quotient
//   special          result came from the special-case path (with out_valid)
//   busy             high in every state except IDLE
//   dbg_state_o      current FSM state encoding for observation
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holding valid keeps its payload stable until that edge, and
// ready never depends combinationally on valid.
module fp_div_seq #(
    parameter int          BITS_PER_CYC = 1,
    parameter logic [31:0] NAN_NUM      = 32'hFF800001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        special,
    output logic        busy,
    output logic [2:0]  dbg_state_o
);

    localparam int QBITS = 26;                  // 24 mantissa + guard + round
    localparam int NCYC  = QBITS / BITS_PER_CYC;
    localparam int CW    = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_DIV   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        C_ZERO = 2'd0,
        C_NORM = 2'd1,
        C_INF  = 2'd2,
        C_NAN  = 2'd3
    } cls_e;

    // Exponent 0 (zero and denormals) is treated as zero.
    function automatic cls_e classify(input logic [31:0] x);
        if (x[30:23] == 8'h00)      return C_ZERO;
        else if (x[30:23] != 8'hFF) return C_NORM;
        else if (x[22:0] == 23'h0)  return C_INF;
        else                        return C_NAN;
    endfunction

    state_e             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [23:0]        mb_q, mb_d;
    logic [25:0]        rem_q, rem_d;
    logic [25:0]        quo_q, quo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [31:0]        out_q, out_d;
    logic               special_q, special_d;

    // Combinational helpers
    cls_e               cls_a, cls_b;
    logic signed [9:0]  ea_s, eb_s, exp_n;
    logic [25:0]        rem_w, quo_w;
    logic [26:0]        diff;
    logic [23:0]        mant;
    logic [24:0]        mant_r;
    logic [23:0]        mant_f;
    logic               inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mb_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            mb_q      <= mb_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            special_q <= special_d;
        end
    end

    // Restoring divide steps for one DIV cycle.
    always_comb begin
        rem_w = rem_q;
        quo_w = quo_q;
        diff  = '0;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            diff = {1'b0, rem_w} - {3'b000, mb_q};
            if (!diff[26]) begin
                rem_w = diff[25:0];
                quo_w = {quo_w[24:0], 1'b1};
            end else begin
                quo_w = {quo_w[24:0], 1'b0};
            end
            rem_w = {rem_w[24:0], 1'b0};
        end
    end

    // Rounding and renormalisation of the finished quotient.
    always_comb begin
        mant = quo_q[25:2];
`ifdef FP_DIV_RNE_EN
        // quo_q[1] = guard, quo_q[0] = round, non-zero remainder = sticky
        inc  = quo_q[1] & (quo_q[0] | (|rem_q) | mant[0]);
`else
        inc  = 1'b0;
`endif
        mant_r = {1'b0, mant} + {24'h0, inc};
        if (mant_r[24]) begin
            mant_f = mant_r[24:1];
            exp_n  = exp_q + 10'sd1;
        end else begin
            mant_f = mant_r[23:0];
            exp_n  = exp_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mb_d      = mb_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        special_d = special_q;
        cls_a     = classify(a_q);
        cls_b     = classify(b_q);
        ea_s      = $signed({2'b00, a_q[30:23]});
        eb_s      = $signed({2'b00, b_q[30:23]});

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d   = S_DONE;
                special_d = 1'b1;
                if (cls_a == C_NAN || cls_b == C_NAN) begin
                    out_d = NAN_NUM;
                end else if ((cls_a == C_ZERO || cls_a == C_NORM) && cls_b == C_INF) begin
                    out_d = 32'h0;
                end else if ((cls_a == C_INF && (cls_b == C_ZERO || cls_b == C_NORM)) ||
                             (cls_a == C_NORM && cls_b == C_ZERO)) begin
                    out_d = {a_q[31], 8'hFF, 23'h0};
                end else if (cls_a == C_NORM && cls_b == C_NORM) begin
                    special_d = 1'b0;
                    state_d   = S_DIV;
                    sign_d    = a_q[31] ^ b_q[31];
                    mb_d      = {1'b1, b_q[22:0]};
                    quo_d     = '0;
                    cnt_d     = CW'(NCYC - 1);
                    // Pre-shift so the first quotient bit is always 1.
                    if (a_q[22:0] < b_q[22:0]) begin
                        rem_d = {1'b0, 1'b1, a_q[22:0], 1'b0};
                        exp_d = ea_s - eb_s + 10'sd126;
                    end else begin
                        rem_d = {2'b00, 1'b1, a_q[22:0]};
                        exp_d = ea_s - eb_s + 10'sd127;
                    end
                end else begin
                    out_d = NAN_NUM;
                end
            end
            S_DIV: begin
                rem_d = rem_w;
                quo_d = quo_w;
                if (cnt_q == '0) begin
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_NORM: begin
                special_d = 1'b0;
                state_d   = S_DONE;
                if (exp_n >= 10'sd255) begin
                    out_d = {sign_q, 8'hFF, 23'h0};
                end else if (exp_n <= 10'sd0) begin
                    out_d = {sign_q, 31'h0};
                end else begin
                    out_d = {sign_q, exp_n[7:0], mant_f[22:0]};
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign out         = out_q;
    assign special     = special_q;
    assign dbg_state_o = state_q;

endmodule
